vga_sync_gen: RTL and testbench

//  - Timing source for the VGA path: generates hsync/vsync, video_on and the current pixel coordinates.
//  - pixel_x, pixel_y and video_on feed the pixel-generation blocks, which return rgb.
//  - Default timing is 640x480 @ 60 Hz, with a 25 MHz pixel rate derived from a 100 MHz clk.

---
 rtl/vga_sync_gen_pkg.sv | 41 ++++
 rtl/vga_sync_gen_if.sv | 29 ++
 rtl/vga_pixel_tick.sv | 43 ++++
 rtl/vga_sync_gen.sv | 121 ++++++++++++
 tb/tb_vga_sync_gen.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/vga_sync_gen_pkg.sv
// ============================================================================
// Module  : vga_sync_gen_pkg
// Brief   : Shared 640x480@60 timing constants, coordinate types and decode
//           helpers used by the VGA timing path and pixel generators.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_sync_gen_pkg;

    localparam int c_h_display = 640;
    localparam int c_h_front   = 16;
    localparam int c_h_sync    = 96;
    localparam int c_h_back    = 48;
    localparam int c_v_display = 480;
    localparam int c_v_front   = 10;
    localparam int c_v_sync    = 2;
    localparam int c_v_back    = 33;

    localparam logic c_sync_active_low  = 1'b0;
    localparam logic c_sync_active_high = 1'b1;

    localparam int c_coord_w   = 10;
    localparam int c_max_total = 1 << c_coord_w;
    localparam int c_div_w     = 4;
    localparam int c_max_div   = 1 << c_div_w;

    typedef logic [c_coord_w-1:0] coord_t;
    typedef logic [c_div_w-1:0]   div_cnt_t;

    function automatic logic in_window(coord_t v, int lo, int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

    function automatic logic sync_level(logic active, logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_sync_gen_if.sv
// ============================================================================
// Module  : vga_sync_gen_if
// Brief   : Timing bundle from the sync generator to the pixel generators.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_sync_gen_if;
    import vga_sync_gen_pkg::*;

    logic   p_tick;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   video_on;
    logic   hsync;
    logic   vsync;
    logic   frame_start;

    modport master (
        output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
    );

    modport slave (
        input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
    );

endinterface

`default_nettype wire

// File: rtl/vga_pixel_tick.sv
// ============================================================================
// Module  : vga_pixel_tick
// Brief   : Clock-enable divider; p_tick is a one-clk strobe every CLK_DIV clks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pixel_tick
    import vga_sync_gen_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    output logic          p_tick,
    output div_cnt_t      div_cnt
);

    localparam div_cnt_t c_last = div_cnt_t'(CLK_DIV - 1);

    div_cnt_t r_div_cnt;
    logic     r_p_tick;
    div_cnt_t w_div_next;

    assign w_div_next = (r_div_cnt == c_last) ? '0 : r_div_cnt + div_cnt_t'(1);

    // Strobe is registered from the next count so it lines up with div_cnt == CLK_DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_p_tick  <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_p_tick  <= (w_div_next == c_last);
        end
    end

    assign p_tick  = r_p_tick;
    assign div_cnt = r_div_cnt;

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module  : vga_sync_gen
// Brief   : VGA timing source: h/v counters with registered sync/video decode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int   CLK_DIV   = 4,
    parameter int   H_DISPLAY = c_h_display,
    parameter int   H_FRONT   = c_h_front,
    parameter int   H_SYNC    = c_h_sync,
    parameter int   H_BACK    = c_h_back,
    parameter int   V_DISPLAY = c_v_display,
    parameter int   V_FRONT   = c_v_front,
    parameter int   V_SYNC    = c_v_sync,
    parameter int   V_BACK    = c_v_back,
    parameter logic SYNC_POL  = c_sync_active_low
) (
    input  wire logic       clk,
    input  wire logic       rst,
    vga_sync_gen_if.master  vga
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t   c_h_last   = coord_t'(H_TOTAL - 1);
    localparam coord_t   c_v_last   = coord_t'(V_TOTAL - 1);
    localparam div_cnt_t c_div_last = div_cnt_t'(CLK_DIV - 1);
    localparam int       c_hs_lo    = H_DISPLAY + H_FRONT;
    localparam int       c_hs_hi    = c_hs_lo + H_SYNC - 1;
    localparam int       c_vs_lo    = V_DISPLAY + V_FRONT;
    localparam int       c_vs_hi    = c_vs_lo + V_SYNC - 1;

    generate
        if (H_TOTAL > c_max_total || V_TOTAL > c_max_total) begin : g_bad_total
            $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed 1024");
        end
        if (CLK_DIV < 1 || CLK_DIV > c_max_div) begin : g_bad_div
            $error("vga_sync_gen: CLK_DIV must be in 1..16");
        end
    endgenerate

    logic     w_p_tick;
    div_cnt_t w_div_cnt;
    logic     w_advance;
    coord_t   w_x_next;
    coord_t   w_y_next;
    logic     w_wrap;

    coord_t   r_x;
    coord_t   r_y;
    logic     r_video_on;
    logic     r_hsync;
    logic     r_vsync;
    logic     r_frame_start;

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk     (clk),
        .rst     (rst),
        .p_tick  (w_p_tick),
        .div_cnt (w_div_cnt)
    );

    // Both terms agree by construction; gating on the count keeps x/y phase-locked to the divider.
    assign w_advance = w_p_tick && (w_div_cnt == c_div_last);

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        w_wrap   = 1'b0;
        if (w_advance) begin
            if (r_x == c_h_last) begin
                w_x_next = '0;
                if (r_y == c_v_last) begin
                    w_y_next = '0;
                    w_wrap   = 1'b1;
                end else begin
                    w_y_next = r_y + coord_t'(1);
                end
            end else begin
                w_x_next = r_x + coord_t'(1);
            end
        end
    end

    // Decode from next-state counters so syncs/video_on change on the same edge as x/y.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x           <= '0;
            r_y           <= '0;
            r_video_on    <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_frame_start <= 1'b0;
        end else begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_video_on    <= (int'(w_x_next) < H_DISPLAY) && (int'(w_y_next) < V_DISPLAY);
            r_hsync       <= sync_level(in_window(w_x_next, c_hs_lo, c_hs_hi), SYNC_POL);
            r_vsync       <= sync_level(in_window(w_y_next, c_vs_lo, c_vs_hi), SYNC_POL);
            r_frame_start <= w_wrap;
        end
    end

    assign vga.p_tick      = w_p_tick;
    assign vga.pixel_x     = r_x;
    assign vga.pixel_y     = r_y;
    assign vga.video_on    = r_video_on;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module  : tb_vga_sync_gen
// Brief   : Two reduced-timing instances (div 4 active-low, div 1 active-high)
//           checked each cycle against an arithmetic timing model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

    localparam int HD = 20, HF = 3, HS = 5, HB = 4;
    localparam int VD = 12, VF = 2, VS = 3, VB = 4;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n   = 0;
    int   tests = 0;
    int   fails = 0;
    bit   checking = 1'b0;

    always #5 clk = ~clk;

    vga_sync_gen_if vif_a ();
    vga_sync_gen_if vif_b ();

    vga_sync_gen #(
        .CLK_DIV(4), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b0)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .vga (vif_a)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .vga (vif_b)
    );

    // n = clk edges since the last reset edge
    always @(posedge clk) n <= rst ? 0 : n + 1;

    // Pixels advanced after n edges: one per CLK_DIV clks, first strobe lands at edge CLK_DIV-1.
    function automatic int advances(int edges, int d);
        if (edges < 1) return 0;
        return (d == 1) ? edges - 1 : edges / d;
    endfunction

    // Vector layout: {p_tick, x[10], y[10], video_on, hsync, vsync, frame_start}
    function automatic logic [24:0] model(int edges, int d, logic pol);
        int k, pos, x, y;
        logic p, von, hs, vs, fs;
        if (edges == 0) return {1'b0, 10'd0, 10'd0, 1'b0, ~pol, ~pol, 1'b0};
        k   = advances(edges, d);
        pos = k % (HT * VT);
        x   = pos % HT;
        y   = pos / HT;
        p   = ((edges % d) == d - 1);
        von = (x < HD) && (y < VD);
        hs  = (x >= HD + HF && x < HD + HF + HS) ? pol : ~pol;
        vs  = (y >= VD + VF && y < VD + VF + VS) ? pol : ~pol;
        fs  = (k != advances(edges - 1, d)) && (pos == 0);
        return {p, 10'(x), 10'(y), von, hs, vs, fs};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [24:0] act [2];
    int          div_of [2]  = '{4, 1};
    logic        pol_of [2]  = '{1'b0, 1'b1};
    int          want_period [2] = '{2688, 672};
    int          want_hs     [2] = '{420, 105};
    int          want_vs     [2] = '{384, 96};
    int          have_fs [2];
    int          w_clk [2], w_vid [2], w_hs [2], w_vs [2];

    always @(negedge clk) begin
        if (checking) begin
            act[0] = {vif_a.p_tick, vif_a.pixel_x, vif_a.pixel_y, vif_a.video_on,
                      vif_a.hsync, vif_a.vsync, vif_a.frame_start};
            act[1] = {vif_b.p_tick, vif_b.pixel_x, vif_b.pixel_y, vif_b.video_on,
                      vif_b.hsync, vif_b.vsync, vif_b.frame_start};
            for (int i = 0; i < 2; i++) begin
                check(i == 0 ? "cycle_a" : "cycle_b", 32'(act[i]), 32'(model(n, div_of[i], pol_of[i])));
                if (n == 0) have_fs[i] = 0;
                if (act[i][0]) begin
                    if (have_fs[i] != 0) begin
                        check("frame_period", 32'(w_clk[i]), 32'(want_period[i]));
                        check("video_ticks", 32'(w_vid[i]), 32'd240);
                        check("hsync_clks", 32'(w_hs[i]), 32'(want_hs[i]));
                        check("vsync_clks", 32'(w_vs[i]), 32'(want_vs[i]));
                    end
                    have_fs[i] = 1;
                    w_clk[i] = 0; w_vid[i] = 0; w_hs[i] = 0; w_vs[i] = 0;
                end
                if (have_fs[i] != 0) begin
                    w_clk[i]++;
                    if (act[i][24] && act[i][3]) w_vid[i]++;
                    if (act[i][2] == pol_of[i]) w_hs[i]++;
                    if (act[i][1] == pol_of[i]) w_vs[i]++;
                end
            end
        end
    end

    initial begin
        logic [24:0] m;
        int          waited;

        // Pin the model with hand-derived points.
        m = model(40, 4, 1'b0);
        check("model_x_at_40", 32'(m[23:14]), 32'd10);
        m = model(2688, 4, 1'b0);
        check("model_wrap_fs", 32'(m[0]), 32'd1);
        m = model(3 + 4 * 25, 4, 1'b0);
        check("model_hsync_x25", 32'({m[23:14], m[2]}), 32'({10'd25, 1'b0}));

        @(posedge clk);
        checking = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a", 32'({vif_a.pixel_x, vif_a.pixel_y, vif_a.hsync, vif_a.vsync, vif_a.video_on, vif_a.p_tick}),
              32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
        check("rst_b_syncs", 32'({vif_b.hsync, vif_b.vsync}), 32'd0);
        rst = 1'b0;

        repeat (40) @(posedge clk);
        @(negedge clk);
        check("x_after_40", 32'(vif_a.pixel_x), 32'd10);

        repeat (3 * 2688 + 100) @(negedge clk);

        // Mid-frame reset inside the hsync window
        waited = 0;
        while (!(vif_a.pixel_x == 10'd26 && vif_a.pixel_y == 10'd10) && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check("reach_26_10", 32'(waited < 3000), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_a", 32'({vif_a.pixel_x, vif_a.pixel_y, vif_a.hsync, vif_a.vsync, vif_a.frame_start}),
              32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0}));
        rst = 1'b0;

        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(200, 4000)) @(negedge clk);
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst = 1'b0;
        end
        repeat (3000) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
